// File: rtl/rs_issue_queue.sv
// rs_issue_queue: age-ordered ALU reservation station snooping NWK tag/value wakeup buses.
// Define RS_ISSUE_BYPASS_EN to let an entry woken this cycle be selected in the same cycle.
module rs_issue_queue #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 5,
  parameter int NWK    = 5,
  parameter int DATA_W = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear,
  input  logic                    dsp_valid,
  output logic                    dsp_ready,
  input  logic [4:0]              dsp_type,
  input  logic [2:0]              dsp_op,
  input  logic [TAG_W-1:0]        dsp_rob_id,
  input  logic [DATA_W-1:0]       dsp_v1,
  input  logic [DATA_W-1:0]       dsp_v2,
  input  logic [DATA_W-1:0]       dsp_imm,
  input  logic                    dsp_q1_valid,
  input  logic                    dsp_q2_valid,
  input  logic [TAG_W-1:0]        dsp_q1,
  input  logic [TAG_W-1:0]        dsp_q2,
  input  logic [NWK-1:0]          wk_valid,
  input  logic [NWK*TAG_W-1:0]    wk_tag,
  input  logic [NWK*DATA_W-1:0]   wk_value,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [4:0]              iss_type,
  output logic [2:0]              iss_op,
  output logic [TAG_W-1:0]        iss_rob_id,
  output logic [DATA_W-1:0]       iss_v1,
  output logic [DATA_W-1:0]       iss_v2,
  output logic [DATA_W-1:0]       iss_imm,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic [4:0]        typ;
    logic [2:0]        op;
    logic [TAG_W-1:0]  rob_id;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] imm;
    logic              q1_valid;
    logic [TAG_W-1:0]  q1;
    logic              q2_valid;
    logic [TAG_W-1:0]  q2;
  } entry_t;

  logic [DEPTH-1:0]  valid_q, valid_d;
  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  // age_q[j][i] set means entry j was dispatched before entry i
  logic [DEPTH-1:0]  age_q [DEPTH];
  logic [DEPTH-1:0]  age_d [DEPTH];
  logic [CW-1:0]     count_q, count_d;

  logic [DEPTH-1:0]  hit1, hit2, ready, grant;
  logic [DATA_W-1:0] val1 [DEPTH];
  logic [DATA_W-1:0] val2 [DEPTH];
  logic              dhit1, dhit2;
  logic [DATA_W-1:0] dval1, dval2;
  logic [IW-1:0]     sel_idx, free_idx;
  logic              dsp_fire, iss_fire;

  // Returns {hit, value}; the lowest matching channel wins.
  function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    for (int c = NWK - 1; c >= 0; c--) begin
      if (wk_valid[c] && (wk_tag[c*TAG_W +: TAG_W] == tag)) begin
        r = {1'b1, wk_value[c*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {hit1[i], val1[i]} = snoop(ent_q[i].q1);
      {hit2[i], val2[i]} = snoop(ent_q[i].q2);
      hit1[i] = hit1[i] & valid_q[i] & ent_q[i].q1_valid;
      hit2[i] = hit2[i] & valid_q[i] & ent_q[i].q2_valid;
    end
    {dhit1, dval1} = snoop(dsp_q1);
    {dhit2, dval2} = snoop(dsp_q2);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_ISSUE_BYPASS_EN
      ready[i] = valid_q[i] && (!ent_q[i].q1_valid || hit1[i]) && (!ent_q[i].q2_valid || hit2[i]);
`else
      ready[i] = valid_q[i] && !ent_q[i].q1_valid && !ent_q[i].q2_valid;
`endif
    end
  end

  // A ready entry is granted only if no other ready entry is older.
  always_comb begin
    grant = ready;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && age_q[j][i]) grant[i] = 1'b0;
      end
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_idx = IW'(i);
    end
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
    end
  end

  assign full       = (count_q == CW'(DEPTH));
  assign dsp_ready  = !full;
  assign count      = count_q;
  assign iss_valid  = |ready;
  assign iss_type   = ent_q[sel_idx].typ;
  assign iss_op     = ent_q[sel_idx].op;
  assign iss_rob_id = ent_q[sel_idx].rob_id;
  assign iss_imm    = ent_q[sel_idx].imm;
`ifdef RS_ISSUE_BYPASS_EN
  assign iss_v1 = ent_q[sel_idx].q1_valid ? val1[sel_idx] : ent_q[sel_idx].v1;
  assign iss_v2 = ent_q[sel_idx].q2_valid ? val2[sel_idx] : ent_q[sel_idx].v2;
`else
  assign iss_v1 = ent_q[sel_idx].v1;
  assign iss_v2 = ent_q[sel_idx].v2;
`endif

  always_comb begin
    valid_d  = valid_q;
    ent_d    = ent_q;
    age_d    = age_q;
    count_d  = count_q;
    dsp_fire = dsp_valid && dsp_ready;
    iss_fire = iss_valid && iss_ready;
    if (clear) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (hit1[i]) begin
          ent_d[i].v1       = val1[i];
          ent_d[i].q1_valid = 1'b0;
        end
        if (hit2[i]) begin
          ent_d[i].v2       = val2[i];
          ent_d[i].q2_valid = 1'b0;
        end
      end
      if (iss_fire) valid_d[sel_idx] = 1'b0;
      // A new entry is younger than every existing entry.
      if (dsp_fire) begin
        valid_d[free_idx]        = 1'b1;
        ent_d[free_idx].typ      = dsp_type;
        ent_d[free_idx].op       = dsp_op;
        ent_d[free_idx].rob_id   = dsp_rob_id;
        ent_d[free_idx].imm      = dsp_imm;
        ent_d[free_idx].q1       = dsp_q1;
        ent_d[free_idx].q2       = dsp_q2;
        ent_d[free_idx].q1_valid = dsp_q1_valid && !dhit1;
        ent_d[free_idx].q2_valid = dsp_q2_valid && !dhit2;
        ent_d[free_idx].v1       = (dsp_q1_valid && dhit1) ? dval1 : dsp_v1;
        ent_d[free_idx].v2       = (dsp_q2_valid && dhit2) ? dval2 : dsp_v2;
        for (int j = 0; j < DEPTH; j++) age_d[j][free_idx] = 1'b1;
        age_d[free_idx] = '0;
      end
      count_d = count_q + CW'(dsp_fire) - CW'(iss_fire);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else if (rdy_in) begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
      age_q   <= age_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb_rs_issue_queue: directed vector table plus hand sequences for rs_issue_queue (default build).
module tb_rs_issue_queue;

  logic         clk_in, rst_in, rdy_in, clear;
  logic         dsp_valid, dsp_ready;
  logic [4:0]   dsp_type;
  logic [2:0]   dsp_op;
  logic [4:0]   dsp_rob_id;
  logic [31:0]  dsp_v1, dsp_v2, dsp_imm;
  logic         dsp_q1_valid, dsp_q2_valid;
  logic [4:0]   dsp_q1, dsp_q2;
  logic [4:0]   wk_valid;
  logic [24:0]  wk_tag;
  logic [159:0] wk_value;
  logic         iss_valid, iss_ready;
  logic [4:0]   iss_type;
  logic [2:0]   iss_op;
  logic [4:0]   iss_rob_id;
  logic [31:0]  iss_v1, iss_v2, iss_imm;
  logic [4:0]   count;
  logic         full;

  int checks = 0;
  int failures = 0;

  rs_issue_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dsp_valid(dsp_valid), .dsp_ready(dsp_ready), .dsp_type(dsp_type), .dsp_op(dsp_op),
    .dsp_rob_id(dsp_rob_id), .dsp_v1(dsp_v1), .dsp_v2(dsp_v2), .dsp_imm(dsp_imm),
    .dsp_q1_valid(dsp_q1_valid), .dsp_q2_valid(dsp_q2_valid), .dsp_q1(dsp_q1), .dsp_q2(dsp_q2),
    .wk_valid(wk_valid), .wk_tag(wk_tag), .wk_value(wk_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_type(iss_type), .iss_op(iss_op),
    .iss_rob_id(iss_rob_id), .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_imm(iss_imm),
    .count(count), .full(full)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        dv;
    logic [4:0]  rob;
    logic [2:0]  op;
    logic [31:0] v1, v2;
    logic        q1v, q2v;
    logic [4:0]  q1, q2;
    logic        w0v, w1v;
    logic [4:0]  w0t, w1t;
    logic [31:0] w0d, w1d;
    logic        ir;
    logic        eValid;
    logic [4:0]  eRob;
    logic [2:0]  eOp;
    logic [31:0] eV1, eV2;
    logic [4:0]  eCount;
  } vec_t;

  // Wakeup tag -1 marks an idle channel.
  function automatic vec_t mkVec(int dv, int rob, int op, int v1, int v2, int q1v, int q1,
                                 int q2v, int q2, int w0t, int w0d, int w1t, int w1d, int ir,
                                 int ev, int erob, int eop, int ev1, int ev2, int ecnt);
    vec_t v;
    v.dv = (dv != 0); v.rob = 5'(rob); v.op = 3'(op); v.v1 = 32'(v1); v.v2 = 32'(v2);
    v.q1v = (q1v != 0); v.q1 = 5'(q1); v.q2v = (q2v != 0); v.q2 = 5'(q2);
    v.w0v = (w0t >= 0); v.w0t = 5'(w0t); v.w0d = 32'(w0d);
    v.w1v = (w1t >= 0); v.w1t = 5'(w1t); v.w1d = 32'(w1d);
    v.ir = (ir != 0); v.eValid = (ev != 0); v.eRob = 5'(erob); v.eOp = 3'(eop);
    v.eV1 = 32'(ev1); v.eV2 = 32'(ev2); v.eCount = 5'(ecnt);
    return v;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    dsp_valid = 0; dsp_type = 0; dsp_op = 0; dsp_rob_id = 0; dsp_v1 = 0; dsp_v2 = 0; dsp_imm = 0;
    dsp_q1_valid = 0; dsp_q2_valid = 0; dsp_q1 = 0; dsp_q2 = 0;
    wk_valid = 0; wk_tag = 0; wk_value = 0; iss_ready = 0; clear = 0;
  endtask

  task automatic setDsp(input int rob, input int op, input int v1, input int v2,
                        input int q1v, input int q1, input int q2v, input int q2);
    dsp_valid = 1; dsp_rob_id = 5'(rob); dsp_op = 3'(op); dsp_type = 5'(op + 1);
    dsp_imm = 32'(rob) << 8; dsp_v1 = 32'(v1); dsp_v2 = 32'(v2);
    dsp_q1_valid = (q1v != 0); dsp_q1 = 5'(q1); dsp_q2_valid = (q2v != 0); dsp_q2 = 5'(q2);
  endtask

  task automatic setWk(input int ch, input int tag, input int val);
    wk_valid[ch] = 1'b1;
    wk_tag[ch*5 +: 5] = 5'(tag);
    wk_value[ch*32 +: 32] = 32'(val);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    setIdle();
    if (v.dv) setDsp(int'(v.rob), int'(v.op), int'(v.v1), int'(v.v2),
                     int'(v.q1v), int'(v.q1), int'(v.q2v), int'(v.q2));
    if (v.w0v) setWk(0, int'(v.w0t), int'(v.w0d));
    if (v.w1v) setWk(1, int'(v.w1t), int'(v.w1d));
    iss_ready = v.ir;
    step();
    checkOutput($sformatf("v%0d iss_valid", idx), 32'(iss_valid), 32'(v.eValid));
    checkOutput($sformatf("v%0d count", idx), 32'(count), 32'(v.eCount));
    checkOutput($sformatf("v%0d dsp_ready", idx), 32'(dsp_ready), 32'(v.eCount != 5'd16));
    if (v.eValid) begin
      checkOutput($sformatf("v%0d iss_rob_id", idx), 32'(iss_rob_id), 32'(v.eRob));
      checkOutput($sformatf("v%0d iss_op", idx), 32'(iss_op), 32'(v.eOp));
      checkOutput($sformatf("v%0d iss_type", idx), 32'(iss_type), 32'(v.eOp) + 1);
      checkOutput($sformatf("v%0d iss_imm", idx), iss_imm, 32'(v.eRob) << 8);
      checkOutput($sformatf("v%0d iss_v1", idx), iss_v1, v.eV1);
      checkOutput($sformatf("v%0d iss_v2", idx), iss_v2, v.eV2);
    end
  endtask

  vec_t vecs [19];

  initial begin
    //                dv rob op  v1     v2     q1v q1 q2v q2  w0t w0d     w1t w1d    ir  ev rob op v1     v2      cnt
    vecs[0]  = mkVec(1, 7, 3, 5,     9,     0, 0, 0, 0,  -1, 0,      -1, 0,     0,  1, 7, 3, 5,     9,      1);
    vecs[1]  = mkVec(0, 0, 0, 0,     0,     0, 0, 0, 0,  -1, 0,      -1, 0,     1,  0, 0, 0, 0,     0,      0);
    vecs[2]  = mkVec(1, 2, 1, 0,     'h22,  1, 4, 0, 0,  -1, 0,      -1, 0,     0,  0, 0, 0, 0,     0,      1);
    vecs[3]  = mkVec(1, 3, 2, 'h31,  'h32,  0, 0, 0, 0,  -1, 0,      -1, 0,     0,  1, 3, 2, 'h31,  'h32,   2);
    vecs[4]  = mkVec(0, 0, 0, 0,     0,     0, 0, 0, 0,  -1, 0,      4,  'hAA,  1,  1, 2, 1, 'hAA,  'h22,   1);
    vecs[5]  = mkVec(0, 0, 0, 0,     0,     0, 0, 0, 0,  -1, 0,      -1, 0,     1,  0, 0, 0, 0,     0,      0);
    vecs[6]  = mkVec(1, 5, 4, 'h51,  0,     0, 0, 1, 6,  6,  'h1234, -1, 0,     0,  1, 5, 4, 'h51,  'h1234, 1);
    vecs[7]  = mkVec(0, 0, 0, 0,     0,     0, 0, 0, 0,  -1, 0,      -1, 0,     1,  0, 0, 0, 0,     0,      0);
    vecs[8]  = mkVec(1, 8, 5, 0,     'h82,  1, 0, 0, 0,  -1, 0,      -1, 0,     0,  0, 0, 0, 0,     0,      1);
    vecs[9]  = mkVec(0, 0, 0, 0,     0,     0, 0, 0, 0,  0,  'h111,  0,  'h222, 0,  1, 8, 5, 'h111, 'h82,   1);
    vecs[10] = mkVec(0, 0, 0, 0,     0,     0, 0, 0, 0,  -1, 0,      -1, 0,     1,  0, 0, 0, 0,     0,      0);
    vecs[11] = mkVec(1, 20, 6, 1,    2,     0, 0, 0, 0,  -1, 0,      -1, 0,     0,  1, 20, 6, 1,    2,      1);
    vecs[12] = mkVec(1, 21, 7, 0,    'h2B,  1, 14, 0, 0, -1, 0,      -1, 0,     0,  1, 20, 6, 1,    2,      2);
    vecs[13] = mkVec(1, 22, 0, 0,    'h2C,  1, 15, 0, 0, -1, 0,      -1, 0,     1,  0, 0, 0, 0,     0,      2);
    vecs[14] = mkVec(1, 23, 1, 'h2D, 0,     0, 0, 1, 15, -1, 0,      -1, 0,     0,  0, 0, 0, 0,     0,      3);
    vecs[15] = mkVec(0, 0, 0, 0,     0,     0, 0, 0, 0,  15, 'h55,   14, 'h44,  0,  1, 21, 7, 'h44, 'h2B,   3);
    vecs[16] = mkVec(0, 0, 0, 0,     0,     0, 0, 0, 0,  -1, 0,      -1, 0,     1,  1, 22, 0, 'h55, 'h2C,   2);
    vecs[17] = mkVec(0, 0, 0, 0,     0,     0, 0, 0, 0,  -1, 0,      -1, 0,     1,  1, 23, 1, 'h2D, 'h55,   1);
    vecs[18] = mkVec(0, 0, 0, 0,     0,     0, 0, 0, 0,  -1, 0,      -1, 0,     1,  0, 0, 0, 0,     0,      0);

    setIdle();
    rdy_in = 1;
    rst_in = 1;
    step();
    step();
    checkOutput("reset iss_valid", 32'(iss_valid), 0);
    checkOutput("reset count", 32'(count), 0);
    checkOutput("reset full", 32'(full), 0);
    checkOutput("reset dsp_ready", 32'(dsp_ready), 1);
    checkOutput("reset iss_rob_id", 32'(iss_rob_id), 0);
    rst_in = 0;

    for (int i = 0; i < 19; i++) applyStimulus(i, vecs[i]);

    // Fill to capacity with entries all waiting on tag 9.
    for (int k = 0; k < 16; k++) begin
      setIdle();
      setDsp(k, k % 8, 0, k, 1, 9, 0, 0);
      step();
    end
    setIdle();
    checkOutput("fill count", 32'(count), 16);
    checkOutput("fill full", 32'(full), 1);
    checkOutput("fill dsp_ready", 32'(dsp_ready), 0);
    checkOutput("fill iss_valid", 32'(iss_valid), 0);
    setDsp(31, 2, 1, 1, 0, 0, 0, 0);
    step();
    setIdle();
    checkOutput("overflow count", 32'(count), 16);
    checkOutput("overflow iss_valid", 32'(iss_valid), 0);
    setWk(2, 9, 'h99);
    step();
    setIdle();
    checkOutput("fill wake iss_valid", 32'(iss_valid), 1);
    checkOutput("fill wake rob", 32'(iss_rob_id), 0);
    checkOutput("fill wake v1", iss_v1, 'h99);
    for (int k = 0; k < 16; k++) begin
      iss_ready = 1;
      step();
      checkOutput($sformatf("drain%0d count", k), 32'(count), 32'(15 - k));
      if (k == 0) checkOutput("drain dsp_ready", 32'(dsp_ready), 1);
      if (k < 15) begin
        checkOutput($sformatf("drain%0d rob", k), 32'(iss_rob_id), 32'(k + 1));
        checkOutput($sformatf("drain%0d v2", k), iss_v2, 32'(k + 1));
      end
    end
    checkOutput("drain iss_valid", 32'(iss_valid), 0);

    // Stall with iss_ready low, then freeze with rdy_in low during a broadcast.
    setIdle();
    setDsp(4, 1, 0, 'h40, 1, 3, 0, 0);
    step();
    setDsp(6, 2, 'h61, 'h62, 0, 0, 0, 0);
    step();
    setIdle();
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("stall%0d rob", k), 32'(iss_rob_id), 6);
      checkOutput($sformatf("stall%0d v1", k), iss_v1, 'h61);
    end
    rdy_in = 0;
    setWk(0, 3, 'h77);
    iss_ready = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      checkOutput($sformatf("hold%0d count", k), 32'(count), 2);
      checkOutput($sformatf("hold%0d rob", k), 32'(iss_rob_id), 6);
    end
    rdy_in = 1;
    setIdle();
    iss_ready = 1;
    step();
    checkOutput("post-hold count", 32'(count), 1);
    checkOutput("post-hold iss_valid", 32'(iss_valid), 0);
    setIdle();
    setWk(0, 3, 'h78);
    step();
    setIdle();
    checkOutput("rewake rob", 32'(iss_rob_id), 4);
    checkOutput("rewake v1", iss_v1, 'h78);
    checkOutput("rewake v2", iss_v2, 'h40);
    iss_ready = 1;
    step();
    checkOutput("rewake drain count", 32'(count), 0);

    // Flush with a simultaneous dispatch and broadcast.
    setIdle();
    for (int k = 0; k < 5; k++) begin
      setDsp(k, 0, 0, 0, 1, 20, 0, 0);
      step();
    end
    setIdle();
    checkOutput("preclear count", 32'(count), 5);
    clear = 1;
    iss_ready = 1;
    setDsp(30, 1, 1, 1, 0, 0, 0, 0);
    setWk(0, 20, 'h5);
    step();
    setIdle();
    checkOutput("clear count", 32'(count), 0);
    checkOutput("clear iss_valid", 32'(iss_valid), 0);
    step();
    checkOutput("post-clear iss_valid", 32'(iss_valid), 0);
    setDsp(1, 5, 'hC1, 'hC2, 0, 0, 0, 0);
    step();
    setIdle();
    checkOutput("post-clear dispatch rob", 32'(iss_rob_id), 1);
    checkOutput("post-clear dispatch count", 32'(count), 1);
    iss_ready = 1;
    step();
    checkOutput("final count", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_issue_queue.md
Name: rs_issue_queue

Overview:
- Parametrised successor to the ALU reservation station.
- Holds DEPTH dispatched ALU ops and snoops NWK tag/value wakeup buses (ALU CDB, LS CDB, ROB read ports, RF forward, …) to resolve operand dependencies.
- Issues the oldest fully-ready entry to the ALU through a valid/ready handshake.
- Sits between the instruction fetcher/decoder and the ALU; adds explicit dependency valid bits, age-ordered selection, an accurate full flag and dispatch-time wakeup capture.

Parameters:
- DEPTH, 16, number of entries (power of two, 2..32)
- TAG_W, 5, ROB id width
- NWK, 5, number of wakeup channels
- DATA_W, 32, operand/immediate width

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset
- rdy_in  in  1  global enable; low freezes all state
- clear  in  1  flush (misprediction)
- dsp_valid  in  1  dispatch request
- dsp_ready  out  1  space available (= !full)
- dsp_type  in  5  instruction class, carried to issue
- dsp_op  in  3  ALU op
- dsp_rob_id  in  TAG_W  destination ROB id
- dsp_v1, dsp_v2, dsp_imm  in  DATA_W each  operand values / immediate
- dsp_q1_valid, dsp_q2_valid  in  1 each  operand pending
- dsp_q1, dsp_q2  in  TAG_W each  producer ROB ids
- wk_valid  in  NWK  per-channel broadcast valid
- wk_tag  in  NWK*TAG_W  channel c at bits [c*TAG_W +: TAG_W]
- wk_value  in  NWK*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- iss_valid  out  1  an entry is presented
- iss_ready  in  1  ALU accepts
- iss_type, iss_op, iss_rob_id, iss_v1, iss_v2, iss_imm  out  issue payload
- count  out  $clog2(DEPTH)+1  occupied entries
- full  out  1  count == DEPTH

Behaviour:
- Reset and clock: one clock clk_in; reset rst_in is synchronous and active-high.
- On reset: all entries invalid, count=0, full=0, dsp_ready=1, iss_valid=0. Payload outputs are don't-care while iss_valid=0, but must be driven from a defined source (entry 0 fields, reset to 0).
- Priority per clock edge: rst_in > !rdy_in (hold everything) > clear > normal operation.
- clear: all valid bits and count go to 0 in one cycle. Dispatch and issue in the same cycle are discarded. Wakeups are ignored.
- Entry state: valid, type, op, rob_id, v1, v2, imm, q1_valid, q1, q2_valid, q2, plus age-matrix row.
- An entry is ready when valid && !q1_valid && !q2_valid, all from registered state.
- Dispatch accepted on dsp_valid && dsp_ready. It writes the lowest-index free slot.
- Dispatch-time capture: if dsp_qN_valid and any wk_valid[c] has wk_tag[c]==dsp_qN in the same cycle, store the wk_value with qN_valid=0. This closes the original dispatch/broadcast race.
- Wakeup: for each valid entry and each operand with qN_valid, on a tag match with valid channel c, capture the value and clear qN_valid.
  - The lowest matching channel index wins; multiple matches are legal.
  - Entries without a pending operand ignore the buses.
  - No ROB id is treated as special; tag 0 is a normal tag.
- Woken entry becomes ready the following cycle (1-cycle wakeup-to-issue), unless RS_ISSUE_BYPASS_EN is defined.
- Select: iss_valid=1 iff at least one entry is ready. The presented entry is the oldest ready entry by dispatch order (age matrix), not by index.
- Issue handshake: the entry is freed on iss_valid && iss_ready.
  - Payload and iss_valid are combinational from registered state.
  - Payload must remain stable while iss_valid && !iss_ready, unless an older entry becomes ready.
- Simultaneous dispatch and issue: count unchanged. The freed slot is not reused in the same cycle (free-slot search uses registered valid bits).
- Full: dsp_ready=0 when count==DEPTH. A dispatch while full is ignored (no state change). Issuing while full re-opens space the next cycle.
- count: +1 on dispatch, -1 on issue, saturates neither way (protocol guarantees range).

Optional Feature:
- RS_ISSUE_BYPASS_EN defined: an entry whose only remaining pending operand(s) match a wakeup in the current cycle counts as ready for select this cycle. The issued v1/v2 come from the matching wk_value, and the entry is freed if accepted.
  - This does not apply to an entry being dispatched this cycle.
- Not defined: strict 1-cycle wakeup-to-issue latency as above.

Test Plan:
- Reset, then dispatch op=3 rob=7 v1=5 v2=9 with no deps -> iss_valid next cycle with rob=7, v1=5, v2=9; iss_ready=1 frees it; count 1->0.
- Dispatch rob=2 (q1=4 pending), then rob=3 (ready) -> rob=3 issues first. Broadcast tag 4 value 0xAA on channel 1 -> rob=2 issues with v1=0xAA one cycle later (two cycles later is a failure; zero latency is permitted only with the macro).
- Dispatch with q2=6 while channel 0 broadcasts tag 6 value 0x1234 in the same cycle -> entry stored ready with v2=0x1234 and never stalls.
- Fill DEPTH=16 entries all pending on tag 9 -> full=1, dsp_ready=0; a 17th dispatch is ignored; broadcast tag 9 -> issues occur oldest-first; count decrements to 0.
- iss_ready held low 3 cycles -> payload stable; rdy_in low 2 cycles during a broadcast -> broadcast ignored and state held.
- 5 entries pending, assert clear together with dsp_valid -> count=0, iss_valid=0 next cycle, new dispatch dropped.
